// File: rtl/matrix_keypad_ctrl_pkg.sv
// Shared types for the matrix keypad controller: event record, scan states, index-width helper.
package keypad_pkg;

    localparam int KW_MAX = 8;

    typedef struct packed {
        logic [KW_MAX-1:0] code;
        logic              press;
    } key_evt_t;

    typedef enum logic {
        DWELL = 1'b0,
        EVAL  = 1'b1
    } scan_state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_keypad_ctrl_if.sv
// Key event stream: FWFT head entry offered with valid/ready.
interface matrix_keypad_ctrl_if #(
    parameter int KW = 4
);
    logic          evt_valid;
    logic          evt_ready;
    logic [KW-1:0] evt_code;
    logic          evt_press;

    modport master (output evt_valid, evt_code, evt_press, input evt_ready);
    modport slave  (input evt_valid, evt_code, evt_press, output evt_ready);
endinterface

// File: rtl/matrix_keypad_ctrl_evt_fifo.sv
// First-word-fall-through event FIFO; pointers carry a wrap bit so full/empty need no counter.
module evt_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         pop_en, push_en;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_en  = pop & ~empty;
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign push_en = push & (~full | pop_en);
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_en) wptr <= wptr + (AW+1)'(1);
            if (pop_en)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/matrix_keypad_ctrl.sv
// Matrix keypad controller: one-cold row scan, per-key debounce, press/release events into a FIFO.
//   state | meaning
//   DWELL | row driven, waiting SCAN_DIV cycles for the columns to settle, then latch them
//   EVAL  | one column per cycle: update that key's debounce counter, maybe emit an event
module matrix_keypad_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int SCAN_DIV    = 2500,
    parameter int DEB_SAMPLES = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [COLS-1:0]        col_i,
    output logic [ROWS-1:0]        row_o,
    output logic [ROWS*COLS-1:0]   key_state,
    matrix_keypad_ctrl_if.master   evt,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    localparam int NK = ROWS * COLS;
    localparam int KW = idx_width(NK);
    localparam int RW = idx_width(ROWS);
    localparam int CW = idx_width(COLS);
    localparam int DW = idx_width(SCAN_DIV);

    logic [COLS-1:0] col_s1, col_s2, samp;
    scan_state_t     state, state_nxt;
    logic [DW-1:0]   dwell_cnt;
    logic [RW-1:0]   row_idx;
    logic [CW-1:0]   col_idx;
    logic [3:0]      deb [NK];
    logic [KW-1:0]   k_idx;
    logic            cur, smp, eval, commit, last_col;
    logic            fifo_empty, fifo_full, drop, unused_code_hi;
    key_evt_t        push_evt, head_evt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= col_i;
            col_s2 <= col_s1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= DWELL;
        else       state <= state_nxt;
    end

    assign last_col = (col_idx == CW'(COLS-1));

    always_comb begin
        state_nxt = state;
        case (state)
            DWELL: if (dwell_cnt == '0) state_nxt = EVAL;
            EVAL:  if (last_col)        state_nxt = DWELL;
            default: state_nxt = DWELL;
        endcase
    end

    // Dwell timer counts down to terminal count zero, reloaded on each row change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dwell_cnt <= DW'(SCAN_DIV-1);
            row_idx   <= '0;
            col_idx   <= '0;
            row_o     <= ~ROWS'(1);
            samp      <= '0;
        end else if (state == DWELL) begin
            if (dwell_cnt == '0) begin
                samp    <= ~col_s2;
                col_idx <= '0;
            end else begin
                dwell_cnt <= dwell_cnt - DW'(1);
            end
        end else if (last_col) begin
            row_o     <= {row_o[ROWS-2:0], row_o[ROWS-1]};
            row_idx   <= (row_idx == RW'(ROWS-1)) ? '0 : row_idx + RW'(1);
            dwell_cnt <= DW'(SCAN_DIV-1);
        end else begin
            col_idx <= col_idx + CW'(1);
        end
    end

    assign eval   = (state == EVAL);
    assign k_idx  = KW'(int'(row_idx) * COLS + int'(col_idx));
    assign cur    = key_state[k_idx];
    assign smp    = samp[col_idx];
    assign commit = eval && (smp != cur) && (deb[k_idx] == 4'(DEB_SAMPLES-1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_state <= '0;
            for (int i = 0; i < NK; i++) deb[i] <= '0;
        end else if (eval) begin
            if (smp == cur) begin
                deb[k_idx] <= '0;
            end else if (commit) begin
                key_state[k_idx] <= ~cur;
                deb[k_idx]       <= '0;
            end else begin
                deb[k_idx] <= deb[k_idx] + 4'd1;
            end
        end
    end

    always_comb begin
        push_evt       = '0;
        push_evt.code  = KW_MAX'(k_idx);
        push_evt.press = ~cur;
    end

    evt_fifo #(
        .W     ($bits(key_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (commit),
        .din   (push_evt),
        .pop   (evt.evt_ready),
        .dout  (head_evt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign evt.evt_valid   = ~fifo_empty;
    assign evt.evt_code    = fifo_empty ? '0 : head_evt.code[KW-1:0];
    assign evt.evt_press   = ~fifo_empty & head_evt.press;
    assign unused_code_hi  = ^(head_evt.code >> KW);

    assign drop = commit & fifo_full & ~(evt.evt_ready & ~fifo_empty);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_matrix_keypad_ctrl.sv
// Bench for matrix_keypad_ctrl: physical keypad model, frame-level debounce reference, event scoreboard.
module tb_matrix_keypad_ctrl;
    localparam int FRAME = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  col_i;
    logic [3:0]  row_o;
    logic [15:0] key_state;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic [15:0] keys = '0;

    matrix_keypad_ctrl_if #(.KW(4)) evt_if ();

    matrix_keypad_ctrl #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_SAMPLES(3), .FIFO_DEPTH(4)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .col_i     (col_i),
        .row_o     (row_o),
        .key_state (key_state),
        .evt       (evt_if),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // A closed key pulls its column low while its row is driven low.
    always_comb begin
        col_i = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_o[r]) col_i[c] = 1'b0;
    end

    typedef struct { int code; int press; } ev_t;
    typedef struct {
        logic [15:0] keys;
        logic [15:0] exp_state;
        int n_evt;
        int code0; int press0;
        int code1; int press1;
    } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   rdy_mode = 1;
    ev_t  got[$];
    ev_t  exp_q[$];
    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle: decide ready for the next edge and log the event that edge will pop.
    task automatic tick();
        @(negedge clk);
        case (rdy_mode)
            0:       evt_if.evt_ready = 1'b0;
            1:       evt_if.evt_ready = 1'b1;
            default: evt_if.evt_ready = 1'($urandom_range(0, 1));
        endcase
        if (evt_if.evt_valid && evt_if.evt_ready)
            got.push_back('{int'(evt_if.evt_code), int'(evt_if.evt_press)});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        tick();
        keys = '0;
        rstn = 1'b0;
        ticks(3);
        rstn = 1'b1;
        got.delete();
    endtask

    logic [3:0]  exp_row;
    logic [15:0] m_state;
    int          m_cnt[16];
    int          idx;
    ev_t         a, b;
    ev_t         ovf_exp[5];

    initial begin
        tbl[0]  = '{16'h0040, 16'h0040, 0, 0, 0, 0, 0};
        tbl[1]  = '{16'h0040, 16'h0040, 0, 0, 0, 0, 0};
        tbl[2]  = '{16'h0000, 16'h0040, 0, 0, 0, 0, 0};
        tbl[3]  = '{16'h0000, 16'h0040, 0, 0, 0, 0, 0};
        tbl[4]  = '{16'h0000, 16'h0000, 1, 6, 0, 0, 0};
        tbl[5]  = '{16'h0040, 16'h0000, 0, 0, 0, 0, 0};
        tbl[6]  = '{16'h0040, 16'h0000, 0, 0, 0, 0, 0};
        tbl[7]  = '{16'h0000, 16'h0000, 0, 0, 0, 0, 0};
        tbl[8]  = '{16'h0040, 16'h0000, 0, 0, 0, 0, 0};
        tbl[9]  = '{16'h0040, 16'h0000, 0, 0, 0, 0, 0};
        tbl[10] = '{16'h0000, 16'h0000, 0, 0, 0, 0, 0};
        tbl[11] = '{16'h0000, 16'h0000, 0, 0, 0, 0, 0};
        tbl[12] = '{16'h8001, 16'h0000, 0, 0, 0, 0, 0};
        tbl[13] = '{16'h8001, 16'h0000, 0, 0, 0, 0, 0};
        tbl[14] = '{16'h8001, 16'h8001, 2, 0, 1, 15, 1};
        tbl[15] = '{16'h0000, 16'h8001, 0, 0, 0, 0, 0};
        tbl[16] = '{16'h0000, 16'h8001, 0, 0, 0, 0, 0};
        tbl[17] = '{16'h0000, 16'h0000, 2, 0, 0, 15, 0};
        ovf_exp = '{'{0, 1}, '{1, 1}, '{2, 1}, '{3, 1}, '{0, 0}};

        evt_if.evt_ready = 1'b1;
        ticks(2);
        chk("rst_row", 32'(row_o), 32'hE);
        chk("rst_keys", 32'(key_state), 0);
        chk("rst_valid", 32'(evt_if.evt_valid), 0);
        chk("rst_code", 32'(evt_if.evt_code), 0);
        chk("rst_press", 32'(evt_if.evt_press), 0);
        chk("rst_ovf", 32'(overflow), 0);
        do_reset();

        // Idle scan: row advances every 8 cycles, E,D,B,7.
        for (int e = 0; e < 10*FRAME; e++) begin
            exp_row = 4'b0001 << ((e / 8) % 4);
            exp_row = ~exp_row;
            chk("idle_row", 32'(row_o), 32'(exp_row));
            tick();
        end
        chk("idle_valid", 32'(evt_if.evt_valid), 0);
        chk("idle_keys", 32'(key_state), 0);

        // Key 6 commit lands on its EVAL cycle in the third frame.
        keys = 16'h0040;
        ticks(78);
        chk("lat_before", 32'(key_state[6]), 0);
        chk("lat_valid_before", 32'(evt_if.evt_valid), 0);
        tick();
        chk("lat_after", 32'(key_state[6]), 1);
        chk("lat_valid", 32'(evt_if.evt_valid), 1);
        chk("lat_code", 32'(evt_if.evt_code), 6);
        chk("lat_press", 32'(evt_if.evt_press), 1);
        ticks(3*FRAME - 79);
        chk("lat_nevt", 32'(got.size()), 1);

        for (int i = 0; i < 18; i++) begin
            keys = tbl[i].keys;
            got.delete();
            ticks(FRAME);
            chk($sformatf("tbl%0d_state", i), 32'(key_state), 32'(tbl[i].exp_state));
            chk($sformatf("tbl%0d_nevt", i), 32'(got.size()), 32'(tbl[i].n_evt));
            if (tbl[i].n_evt > 0 && got.size() > 0) begin
                chk($sformatf("tbl%0d_code0", i), 32'(got[0].code), 32'(tbl[i].code0));
                chk($sformatf("tbl%0d_press0", i), 32'(got[0].press), 32'(tbl[i].press0));
            end
            if (tbl[i].n_evt > 1 && got.size() > 1) begin
                chk($sformatf("tbl%0d_code1", i), 32'(got[1].code), 32'(tbl[i].code1));
                chk($sformatf("tbl%0d_press1", i), 32'(got[1].press), 32'(tbl[i].press1));
            end
        end

        // Overflow: five presses into a 4-deep FIFO with nobody reading.
        do_reset();
        rdy_mode = 0;
        keys = 16'h001F;
        ticks(76);
        chk("ovf_before", 32'(overflow), 0);
        tick();
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_key4", 32'(key_state[4]), 1);
        ticks(19);
        chk("ovf_keys", 32'(key_state), 32'h1F);
        chk("ovf_valid", 32'(evt_if.evt_valid), 1);
        chk("ovf_head", 32'(evt_if.evt_code), 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        // Release key 0; its push meets a one-cycle pop while full.
        keys = 16'h001E;
        ticks(66);
        rdy_mode = 1;
        tick();
        rdy_mode = 0;
        tick();
        chk("full_pop_ovf", 32'(overflow), 0);
        chk("full_pop_valid", 32'(evt_if.evt_valid), 1);
        chk("full_pop_keys", 32'(key_state), 32'h1E);
        ticks(27);
        rdy_mode = 1;
        ticks(8);
        chk("full_nevt", 32'(got.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) begin
                chk($sformatf("full_code%0d", i), 32'(got[i].code), 32'(ovf_exp[i].code));
                chk($sformatf("full_press%0d", i), 32'(got[i].press), 32'(ovf_exp[i].press));
            end
        end
        chk("full_drained", 32'(evt_if.evt_valid), 0);

        // Reset mid-EVAL with two events queued.
        do_reset();
        rdy_mode = 0;
        keys = 16'h0003;
        ticks(70);
        chk("mid_valid_pre", 32'(evt_if.evt_valid), 1);
        rstn = 1'b0;
        #1;
        chk("mid_valid", 32'(evt_if.evt_valid), 0);
        chk("mid_row", 32'(row_o), 32'hE);
        chk("mid_keys", 32'(key_state), 0);
        keys = '0;
        ticks(3);
        rstn = 1'b1;
        rdy_mode = 1;
        got.delete();
        ticks(4*FRAME);
        chk("mid_noevt", 32'(got.size()), 0);
        chk("mid_keys_after", 32'(key_state), 0);

        // Random key activity against a frame-level debounce reference.
        do_reset();
        rdy_mode = 2;
        m_state = '0;
        for (int k = 0; k < 16; k++) m_cnt[k] = 0;
        exp_q.delete();
        for (int f = 0; f < 41; f++) begin
            if (f == 40) rdy_mode = 1;
            else if ($urandom_range(0, 1) == 1) begin
                idx = int'($urandom_range(0, 15));
                keys[idx] = ~keys[idx];
            end
            ticks(FRAME);
            for (int k = 0; k < 16; k++) begin
                if (keys[k] != m_state[k]) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == 3) begin
                        m_state[k] = keys[k];
                        m_cnt[k] = 0;
                        exp_q.push_back('{k, int'(keys[k])});
                    end
                end else begin
                    m_cnt[k] = 0;
                end
            end
            chk($sformatf("rand%0d_state", f), 32'(key_state), 32'(m_state));
            while (got.size() > 0 && exp_q.size() > 0) begin
                a = got.pop_front();
                b = exp_q.pop_front();
                chk("rand_code", 32'(a.code), 32'(b.code));
                chk("rand_press", 32'(a.press), 32'(b.press));
            end
        end
        chk("rand_extra_got", 32'(got.size()), 0);
        chk("rand_missing", 32'(exp_q.size()), 0);
        chk("rand_ovf", 32'(overflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
